// File: rtl/iq_pair_sched.sv
// ---------------------------------------------------------------------------
// iq_pair_sched
//
// Sits between the interleaved 12-bit IQ sample bus and the demodulator.
// Incoming samples are paired as (I, Q) by a two-state ordering FSM.
// Completed pairs are decimated by a run-time factor and then staged for one
// cycle. They are queued in a small first-word-fall-through FIFO and leave on
// a valid/ready handshake.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : synchronous reset, active low
//   enable     : 1 = accept samples, 0 = pairing idle (FIFO keeps draining)
//   decim      : keep 1 of every decim+1 pairs, captured on enable 0->1
//   iq_valid   : sample strobe
//   iq_sel     : 1 = sample is I, 0 = sample is Q
//   iq_in      : two's-complement sample
//   out_i      : I of FIFO head pair (0 while empty)
//   out_q      : Q of FIFO head pair (0 while empty)
//   out_valid  : FIFO not empty
//   out_ready  : downstream accepts the head pair
//   pair_err   : one-cycle pulse on an out-of-order sample
//   overflow   : sticky, a pair was dropped on a full FIFO
//   ovf_clr    : clears overflow (a simultaneous drop wins)
//   fill       : current FIFO occupancy
// ---------------------------------------------------------------------------
module iq_pair_sched #(
  parameter int DW    = 12,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [7:0]                  decim,
  input  logic                        iq_valid,
  input  logic                        iq_sel,
  input  logic signed [DW-1:0]        iq_in,
  output logic signed [DW-1:0]        out_i,
  output logic signed [DW-1:0]        out_q,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        pair_err,
  output logic                        overflow,
  input  logic                        ovf_clr,
  output logic [$clog2(DEPTH):0]      fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    WAIT_I = 1'b0,
    WAIT_Q = 1'b1
  } pair_state_e;

  // Pairing FSM and its registered error pulse
  pair_state_e          state_q;
  logic                 pair_err_q;
  logic signed [DW-1:0] i_lat_q;

  // Decimation control
  logic                 en_prev_q;
  logic [7:0]           dcap_q, dcap_d;
  logic [7:0]           dcnt_q, dcnt_d;

  // Staged pair waiting for its FIFO push
  logic                 vld_p1_q, vld_p1_d;
  logic signed [DW-1:0] pair_i_p1_q;
  logic signed [DW-1:0] pair_q_p1_q;

  // FIFO storage and control
  logic signed [DW-1:0] mem_i [DEPTH];
  logic signed [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 overflow_q, overflow_d;

  // Sample classification
  logic                 acc;
  logic                 take_i;
  logic                 err_s;
  logic                 complete;
  logic                 en_rise;

  // FIFO handshake
  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 wr_ok;
  logic                 drop;

  assign acc     = enable & iq_valid;
  assign en_rise = enable & ~en_prev_q;

  // An I in WAIT_Q is both an error and a fresh latch: the newest I wins.
  always_comb begin
    take_i   = 1'b0;
    err_s    = 1'b0;
    complete = 1'b0;
    if (acc) begin
      case (state_q)
        WAIT_I: begin
          if (iq_sel) take_i = 1'b1;
          else        err_s  = 1'b1;
        end
        WAIT_Q: begin
          if (iq_sel) begin
            take_i = 1'b1;
            err_s  = 1'b1;
          end else begin
            complete = 1'b1;
          end
        end
        default: begin
          take_i   = 1'b0;
          err_s    = 1'b0;
          complete = 1'b0;
        end
      endcase
    end
  end

  // Pairing FSM: disabling forces WAIT_I, which discards any latched I.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= WAIT_I;
      pair_err_q <= 1'b0;
    end else begin
      pair_err_q <= err_s;
      if (!enable)       state_q <= WAIT_I;
      else if (take_i)   state_q <= WAIT_Q;
      else if (complete) state_q <= WAIT_I;
    end
  end

  // Decimation: counter is parked at 0 while disabled so the first pair
  // after enabling is always forwarded. decim only matters at enable 0->1.
  always_comb begin
    dcap_d = en_rise ? decim : dcap_q;
    dcnt_d = dcnt_q;
    if (!enable) begin
      dcnt_d = 8'd0;
    end else if (complete) begin
      dcnt_d = (dcnt_q == 8'd0) ? dcap_q : dcnt_q - 8'd1;
    end
    vld_p1_d = complete & (dcnt_q == 8'd0);
  end

  // FIFO control; a push into a full FIFO is accepted only if the head
  // leaves in the same cycle.
  assign empty = (cnt_q == CW'(0));
  assign full  = (cnt_q == CW'(DEPTH));
  assign push  = vld_p1_q;
  assign pop   = ~empty & out_ready;
  assign wr_ok = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({wr_ok, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // A drop in the same cycle as a clear leaves the flag set.
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
    else              overflow_d = overflow_q;
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_prev_q  <= 1'b0;
      dcap_q     <= 8'd0;
      dcnt_q     <= 8'd0;
      vld_p1_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      en_prev_q  <= enable;
      dcap_q     <= dcap_d;
      dcnt_q     <= dcnt_d;
      vld_p1_q   <= vld_p1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // ---- p0: sample capture (latched I) ----
  always_ff @(posedge clk) begin
    if (take_i) i_lat_q <= iq_in;
  end

  // ---- p1: completed pair staged for the FIFO ----
  always_ff @(posedge clk) begin
    if (complete) begin
      pair_i_p1_q <= i_lat_q;
      pair_q_p1_q <= iq_in;
    end
  end

  // ---- p2: FIFO storage ----
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_i[wr_ptr_q] <= pair_i_p1_q;
      mem_q[wr_ptr_q] <= pair_q_p1_q;
    end
  end

  // Head is gated to zero while empty so reset and idle show clean outputs
  // without resetting the storage array.
  assign out_valid = ~empty;
  assign out_i     = empty ? '0 : mem_i[rd_ptr_q];
  assign out_q     = empty ? '0 : mem_q[rd_ptr_q];
  assign pair_err  = pair_err_q;
  assign overflow  = overflow_q;
  assign fill      = cnt_q;

endmodule

// File: tb/tb_iq_pair_sched.sv
module tb_iq_pair_sched;

  localparam int DW    = 12;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [7:0]    decim;
  logic          iq_valid;
  logic          iq_sel;
  logic [DW-1:0] iq_in;
  logic [DW-1:0] out_i;
  logic [DW-1:0] out_q;
  logic          out_valid;
  logic          out_ready;
  logic          pair_err;
  logic          overflow;
  logic          ovf_clr;
  logic [$clog2(DEPTH):0] fill;

  int checks   = 0;
  int failures = 0;
  int obs_err  = 0;

  // Pairs observed leaving the DUT (valid & ready before an edge)
  logic [2*DW-1:0] got[$];

  // Behavioural reference: pairing by "have an I" flag, decimation by
  // pair index modulo (decim+1), FIFO as a bounded queue.
  logic [2*DW-1:0] m_q[$];
  bit              m_stage_v;
  logic [2*DW-1:0] m_stage;
  bit              m_have_i;
  logic [DW-1:0]   m_i;
  int              m_pos;
  int              m_dec;
  bit              m_en_prev;
  bit              m_ovf;
  bit              m_err;

  iq_pair_sched #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .decim     (decim),
    .iq_valid  (iq_valid),
    .iq_sel    (iq_sel),
    .iq_in     (iq_in),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pair_err  (pair_err),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .fill      (fill)
  );

  always #5 clk = ~clk;

  // Advance one clock: update the reference from the inputs present at the
  // edge, then sample the DUT 1 ns after the edge.
  task automatic tick();
    bit drop;
    if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back({out_i, out_q});
    if (!rst_n) begin
      m_q.delete();
      m_stage_v = 0; m_have_i = 0; m_pos = 0; m_dec = 0;
      m_en_prev = 0; m_ovf = 0; m_err = 0;
    end else begin
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      drop = 0;
      if (m_stage_v) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_stage);
        else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      m_stage_v = 0;
      m_err = 0;
      if (!enable) begin
        m_have_i = 0;
        m_pos = 0;
      end else begin
        if (!m_en_prev) m_dec = decim;
        if (iq_valid) begin
          if (iq_sel) begin
            if (m_have_i) m_err = 1;
            m_have_i = 1;
            m_i = iq_in;
          end else if (!m_have_i) begin
            m_err = 1;
          end else begin
            m_have_i = 0;
            if (m_pos % (m_dec + 1) == 0) begin
              m_stage_v = 1;
              m_stage = {m_i, iq_in};
            end
            m_pos++;
          end
        end
      end
      m_en_prev = enable;
    end
    @(posedge clk);
    #1;
    if (pair_err === 1'b1) obs_err++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send(input bit sel, input logic [DW-1:0] d);
    iq_valid = 1'b1; iq_sel = sel; iq_in = d;
    tick();
    iq_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [DW-1:0] i, input logic [DW-1:0] q);
    send(1'b1, i);
    send(1'b0, q);
  endtask

  task automatic do_reset(input bit en, input logic [7:0] dec);
    rst_n = 1'b0; enable = en; decim = dec; iq_valid = 1'b0; iq_sel = 1'b0;
    iq_in = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    idle(2);
    rst_n = 1'b1;
    tick();
    got.delete();
  endtask

  task automatic test_reset();
    do_reset(1'b0, 8'd0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (fill !== 3'd0) begin failures++; $display("FAIL reset_fill: got %0d expected 0", fill); end
    checks++; if (out_i !== 12'h000 || out_q !== 12'h000) begin failures++; $display("FAIL reset_data: got %h/%h expected 000/000", out_i, out_q); end
    checks++; if (overflow !== 1'b0 || pair_err !== 1'b0) begin failures++; $display("FAIL reset_flags: got ovf=%b err=%b expected 0/0", overflow, pair_err); end
  endtask

  task automatic test_basic_pairing();
    int e0;
    do_reset(1'b1, 8'd0);
    out_ready = 1'b1;
    e0 = obs_err;
    send(1'b1, 12'h123);
    send(1'b0, 12'hABC);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_latency: out_valid got %b expected 0 on Q edge", out_valid); end
    send(1'b1, 12'h7FF);
    checks++; if (out_valid !== 1'b1 || out_i !== 12'h123 || out_q !== 12'hABC) begin failures++; $display("FAIL basic_pair0: got v=%b %h/%h expected 1 123/ABC", out_valid, out_i, out_q); end
    send(1'b0, 12'h800);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_pop0: out_valid got %b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_i !== 12'h7FF || out_q !== 12'h800) begin failures++; $display("FAIL basic_pair1: got v=%b %h/%h expected 1 7FF/800", out_valid, out_i, out_q); end
    tick();
    checks++; if (fill !== 3'd0 || obs_err != e0) begin failures++; $display("FAIL basic_end: got fill=%0d errs=%0d expected 0/0", fill, obs_err - e0); end
  endtask

  task automatic test_ordering_errors();
    int e0;
    do_reset(1'b1, 8'd0);
    out_ready = 1'b1;
    e0 = obs_err;
    send(1'b0, 12'h001);
    checks++; if (pair_err !== 1'b1) begin failures++; $display("FAIL order_err_q_first: pair_err got %b expected 1", pair_err); end
    send(1'b1, 12'h010);
    checks++; if (pair_err !== 1'b0) begin failures++; $display("FAIL order_err_width: pair_err got %b expected 0", pair_err); end
    send(1'b1, 12'h020);
    checks++; if (pair_err !== 1'b1) begin failures++; $display("FAIL order_err_double_i: pair_err got %b expected 1", pair_err); end
    send(1'b0, 12'h030);
    tick();
    checks++; if (out_valid !== 1'b1 || out_i !== 12'h020 || out_q !== 12'h030) begin failures++; $display("FAIL order_pair: got v=%b %h/%h expected 1 020/030", out_valid, out_i, out_q); end
    tick();
    checks++; if (fill !== 3'd0 || obs_err - e0 != 2 || got.size() != 1) begin failures++; $display("FAIL order_totals: got fill=%0d errs=%0d pairs=%0d expected 0/2/1", fill, obs_err - e0, got.size()); end
  endtask

  task automatic test_decimation();
    do_reset(1'b0, 8'd2);
    out_ready = 1'b1;
    enable = 1'b1;
    tick();
    got.delete();
    for (int k = 0; k < 9; k++) begin
      if (k == 4) decim = 8'd0;
      send_pair(12'(k), 12'(k + 'h100));
    end
    idle(2);
    checks++; if (got.size() != 3) begin failures++; $display("FAIL decim_count: got %0d pairs expected 3", got.size()); end
    for (int j = 0; j < 3 && j < got.size(); j++) begin
      checks++;
      if (got[j] !== {12'(3*j), 12'(3*j + 'h100)}) begin failures++; $display("FAIL decim_pair%0d: got %h expected %h", j, got[j], {12'(3*j), 12'(3*j + 'h100)}); end
    end
    enable = 1'b0; tick();
    enable = 1'b1; tick();
    got.delete();
    for (int k = 9; k < 12; k++) send_pair(12'(k), 12'(k + 'h100));
    idle(2);
    checks++; if (got.size() != 3) begin failures++; $display("FAIL decim_recapture: got %0d pairs expected 3", got.size()); end
    checks++; if (got.size() == 3 && got[2] !== {12'h00B, 12'h10B}) begin failures++; $display("FAIL decim_recapture_last: got %h expected 00B10B", got[2]); end
  endtask

  task automatic test_backpressure_full();
    do_reset(1'b1, 8'd0);
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) send_pair(12'(k + 'h200), 12'(k + 'h300));
    tick();
    checks++; if (fill !== 3'd4) begin failures++; $display("FAIL bp_fill: got %0d expected 4", fill); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow: got %b expected 1", overflow); end
    checks++; if (out_i !== 12'h200 || out_q !== 12'h300) begin failures++; $display("FAIL bp_head: got %h/%h expected 200/300", out_i, out_q); end
    send_pair(12'h2EE, 12'h3EE);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_clr_vs_drop: got %b expected 1", overflow); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL bp_clr: got %b expected 0", overflow); end
    out_ready = 1'b1;
    got.delete();
    idle(5);
    checks++; if (got.size() != 4 || fill !== 3'd0) begin failures++; $display("FAIL bp_drain: got %0d pairs fill=%0d expected 4/0", got.size(), fill); end
    for (int j = 0; j < 4 && j < got.size(); j++) begin
      checks++;
      if (got[j] !== {12'(j + 'h200), 12'(j + 'h300)}) begin failures++; $display("FAIL bp_order%0d: got %h expected %h", j, got[j], {12'(j + 'h200), 12'(j + 'h300)}); end
    end
  endtask

  task automatic test_full_with_pop();
    do_reset(1'b1, 8'd0);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_pair(12'(k + 'h400), 12'(k + 'h500));
    tick();
    send_pair(12'h4AA, 12'h5AA);
    got.delete();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (fill !== 3'd4 || overflow !== 1'b0) begin failures++; $display("FAIL fullpop_flags: got fill=%0d ovf=%b expected 4/0", fill, overflow); end
    checks++; if (out_i !== 12'h401 || out_q !== 12'h501) begin failures++; $display("FAIL fullpop_head: got %h/%h expected 401/501", out_i, out_q); end
    out_ready = 1'b1;
    idle(5);
    checks++; if (got.size() != 5 || got[4] !== {12'h4AA, 12'h5AA}) begin failures++; $display("FAIL fullpop_tail: got %0d pairs last=%h expected 5 4AA5AA", got.size(), got.size() > 0 ? got[got.size()-1] : 24'h0); end
  endtask

  task automatic test_enable_and_reset_mid();
    int e0;
    do_reset(1'b1, 8'd0);
    out_ready = 1'b1;
    send(1'b1, 12'h111);
    enable = 1'b0; tick(); enable = 1'b1;
    e0 = obs_err;
    send(1'b0, 12'h222);
    checks++; if (pair_err !== 1'b1) begin failures++; $display("FAIL en_mid_err: pair_err got %b expected 1", pair_err); end
    idle(3);
    checks++; if (fill !== 3'd0 || out_valid !== 1'b0 || obs_err - e0 != 1) begin failures++; $display("FAIL en_mid_nopair: got fill=%0d v=%b errs=%0d expected 0/0/1", fill, out_valid, obs_err - e0); end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send_pair(12'(k + 'h600), 12'(k + 'h700));
    tick();
    checks++; if (fill !== 3'd3) begin failures++; $display("FAIL rst_mid_prefill: got %0d expected 3", fill); end
    send(1'b1, 12'h6AA);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++; if (fill !== 3'd0 || out_valid !== 1'b0 || out_i !== 12'h000 || out_q !== 12'h000) begin failures++; $display("FAIL rst_mid_clear: got fill=%0d v=%b %h/%h expected 0/0 000/000", fill, out_valid, out_i, out_q); end
    e0 = obs_err;
    send(1'b0, 12'h7AA);
    idle(2);
    checks++; if (fill !== 3'd0 || obs_err - e0 != 1) begin failures++; $display("FAIL rst_mid_latch_lost: got fill=%0d errs=%0d expected 0/1", fill, obs_err - e0); end
  endtask

  task automatic test_random();
    bit nsel;
    do_reset(1'b1, 8'($urandom_range(0, 3)));
    nsel = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      iq_valid = ($urandom_range(0, 3) != 0);
      iq_sel   = ($urandom_range(0, 15) == 0) ? ~nsel : nsel;
      if (iq_valid && enable) nsel = ~iq_sel;
      iq_in    = 12'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) begin
        enable = ~enable;
        if (!enable) begin decim = 8'($urandom_range(0, 3)); nsel = 1'b1; end
      end
      tick();
      checks++; if (fill !== 3'(m_q.size())) begin failures++; $display("FAIL rand_fill c=%0d: got %0d expected %0d", c, fill, m_q.size()); end
      checks++; if (out_valid !== (m_q.size() > 0)) begin failures++; $display("FAIL rand_valid c=%0d: got %b expected %b", c, out_valid, m_q.size() > 0); end
      checks++; if ({out_i, out_q} !== ((m_q.size() > 0) ? m_q[0] : 24'h0)) begin failures++; $display("FAIL rand_head c=%0d: got %h/%h expected %h", c, out_i, out_q, (m_q.size() > 0) ? m_q[0] : 24'h0); end
      checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rand_ovf c=%0d: got %b expected %b", c, overflow, m_ovf); end
      checks++; if (pair_err !== m_err) begin failures++; $display("FAIL rand_err c=%0d: got %b expected %b", c, pair_err, m_err); end
    end
    iq_valid = 1'b0; ovf_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; decim = 8'd0; iq_valid = 1'b0; iq_sel = 1'b0;
    iq_in = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    #1;
    test_reset();
    test_basic_pairing();
    test_ordering_errors();
    test_decimation();
    test_backpressure_full();
    test_full_with_pop();
    test_enable_and_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
